// File: rtl/doa_scan_ctrl.sv
// Direction-of-arrival sweep sequencer: walks the steering ROM over every look
// direction, follows the delayed power returns and reports the strongest angle.
module doa_scan_ctrl #(
   parameter int WORD_LENGTH     = 16,
   parameter int WORD_LENGTH_OUT = (WORD_LENGTH*2+3)*2+1,
   parameter int N_ANGLES        = 181,
   parameter int ADDR_W          = 8,
   parameter int PIPE_LAT        = 3
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              abort,
   input  logic signed [WORD_LENGTH_OUT-1:0] pwr_in,
   output logic [ADDR_W-1:0]                 steer_addr,
   output logic                              steer_valid,
   output logic                              x_hold,
   output logic                              busy,
   output logic                              done,
   output logic [ADDR_W-1:0]                 peak_idx,
   output logic signed [WORD_LENGTH_OUT-1:0] peak_pwr
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ANGLES - 1);
   localparam logic signed [WORD_LENGTH_OUT-1:0] MOST_NEG =
      {1'b1, {(WORD_LENGTH_OUT-1){1'b0}}};

   state_t                            state_reg, state_next;
   logic [ADDR_W-1:0]                 addr_reg;
   logic [ADDR_W-1:0]                 ret_reg;
   logic [ADDR_W-1:0]                 idx_reg;
   logic [ADDR_W-1:0]                 peak_idx_reg;
   logic signed [WORD_LENGTH_OUT-1:0] max_reg;
   logic signed [WORD_LENGTH_OUT-1:0] peak_pwr_reg;
   logic [PIPE_LAT-1:0]               dl_reg, dl_next;
   logic                              launch, flush, tap, pending, load_peak;

   assign launch  = (state_reg == IDLE) && start && !abort;
   assign flush   = (state_reg != IDLE) && abort;
   assign tap     = dl_reg[PIPE_LAT-1];
   // Any valid still travelling behind the tap keeps the sweep draining.
   assign pending = |(dl_reg << 1);

   genvar gi;
   generate
      for (gi = 0; gi < PIPE_LAT; gi++) begin : g_dl
         if (gi == 0) begin : g_head
            assign dl_next[gi] = steer_valid & ~flush;
         end else begin : g_body
            assign dl_next[gi] = dl_reg[gi-1] & ~flush;
         end
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      steer_valid = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      load_peak   = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (launch) state_next = ISSUE;
         end
         ISSUE: begin
            steer_valid = 1'b1;
            if (abort)                      state_next = IDLE;
            else if (addr_reg == LAST_ADDR) state_next = DRAIN;
         end
         DRAIN: begin
            if (abort)         state_next = IDLE;
            else if (!pending) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
            done       = !abort;
            load_peak  = !abort;
         end
         default: state_next = IDLE;
      endcase
   end

   assign x_hold     = busy;
   assign steer_addr = addr_reg;
   // The result is shown combinationally in the DONE cycle so an abort there can still veto it.
   assign peak_idx   = load_peak ? idx_reg : peak_idx_reg;
   assign peak_pwr   = load_peak ? max_reg : peak_pwr_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_reg     <= '0;
         ret_reg      <= '0;
         idx_reg      <= '0;
         max_reg      <= '0;
         peak_idx_reg <= '0;
         peak_pwr_reg <= '0;
         dl_reg       <= '0;
      end else begin
         dl_reg <= dl_next;

         if (launch)
            addr_reg <= '0;
         else if (state_reg == ISSUE && addr_reg != LAST_ADDR)
            addr_reg <= addr_reg + 1'b1;

         if (launch) begin
            max_reg <= MOST_NEG;
            idx_reg <= '0;
            ret_reg <= '0;
         end else if (tap) begin
            ret_reg <= ret_reg + 1'b1;
            if (pwr_in > max_reg) begin
               max_reg <= pwr_in;
               idx_reg <= ret_reg;
            end
         end

         if (load_peak) begin
            peak_idx_reg <= idx_reg;
            peak_pwr_reg <= max_reg;
         end
      end
   end

endmodule
